// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_prog
// Description : Programmable integer clock divider with glitch-free divisor
//               updates at period boundaries and clean start/stop enable.
//               Optional macro CLK_DIV_PROG_STATUS_EN adds period_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             upd_pend,
`ifdef CLK_DIV_PROG_STATUS_EN
    output logic             cfg_err,
    output logic [15:0]      period_cnt
`else
    output logic             cfg_err
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;

    logic             w_legal;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_high_len;

    assign w_legal    = div_in > CNT_W'(1);
    assign w_last     = (cnt_q == (div_cur_q - CNT_W'(1)));
    assign w_cnt_inc  = cnt_q + CNT_W'(1);
    // High phase is ceil(N/2) cycles, so odd divisors favour the high phase.
    assign w_high_len = div_cur_q - (div_cur_q >> 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        div_cur_d = div_cur_q;
        pend_d    = pend_q;
        upd_d     = upd_q;
        err_d     = div_load && !w_legal;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (div_load && w_legal) begin
                    div_cur_d = div_in;
                end
                if (en) begin
                    state_d = S_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    cnt_d = '0;
                    if (!en) begin
                        state_d = S_IDLE;
                        clk_d   = 1'b0;
                    end else begin
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                        if (upd_q) begin
                            div_cur_d = pend_q;
                            upd_d     = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                    clk_d = (w_cnt_inc < w_high_len);
                end
                // A load on the boundary edge re-arms pending after the swap above.
                if (div_load && w_legal) begin
                    pend_d = div_in;
                    upd_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            div_cur_q <= CNT_W'(DEFAULT_DIV);
            pend_q    <= '0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
        end
    end

`ifdef CLK_DIV_PROG_STATUS_EN
    logic [15:0] period_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_cnt_q <= '0;
        end else if ((state_q == S_RUN) && w_last && (period_cnt_q != 16'hFFFF)) begin
            period_cnt_q <= period_cnt_q + 16'd1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    assign clk_out  = clk_q;
    assign tick     = tick_q;
    assign div_cur  = div_cur_q;
    assign upd_pend = upd_q;
    assign cfg_err  = err_q;

endmodule
`default_nettype wire
